// File: rtl/sram_bank_writer.sv
// ============================================================================
// Module   : sram_bank_writer
// Purpose  : Scatters a result stream across a banked SRAM group, one byte
//            lane per element, with ping-pong buffer select per frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_bank_writer #(
    parameter int NUM_BANKS = 9,
    parameter int LANES     = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int LEN_W     = 14
) (
    input  logic                 clk,
    input  logic                 srstn,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     frame_len,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_ready,
    output logic [NUM_BANKS-1:0] sram_write_enable,
    output logic [LANES-1:0]     sram_bytemask,
    output logic [ADDR_W-1:0]    sram_waddr,
    output logic [DATA_W-1:0]    sram_wdata,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 mem_sel
);

    localparam int C_LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int C_BANK_W = $clog2(NUM_BANKS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [C_LANE_W-1:0]   lane_q, lane_d;
    logic [C_BANK_W-1:0]   bank_q, bank_d;
    logic [ADDR_W-1:0]     word_q, word_d;
    logic [LEN_W-1:0]      elem_q, elem_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [NUM_BANKS-1:0]  we_q, we_d;
    logic [LANES-1:0]      mask_q, mask_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  mem_sel_q, mem_sel_d;

    logic                  w_xfer;
    logic [LEN_W-1:0]      w_elem_next;

    assign in_ready    = (state_q == S_RUN);
    assign w_xfer      = in_valid & in_ready;
    assign w_elem_next = elem_q + LEN_W'(1);

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        bank_d       = bank_q;
        word_d       = word_q;
        elem_d       = elem_q;
        len_d        = len_q;
        we_d         = '0;
        mask_d       = '1;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;
        mem_sel_d    = mem_sel_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_d = base_addr;
                    len_d  = frame_len;
                    lane_d = '0;
                    bank_d = '0;
                    elem_d = '0;
                    if (frame_len == '0) begin
                        state_d      = S_DONE;
                        frame_done_d = 1'b1;
                        mem_sel_d    = ~mem_sel_q;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_xfer) begin
                    we_d    = NUM_BANKS'(1) << bank_q;
                    mask_d  = ~(LANES'(1) << lane_q);
                    waddr_d = word_q;
                    wdata_d = in_data;
                    elem_d  = w_elem_next;
                    // lane -> bank -> word cascade replaces k/LANES and k/(LANES*NUM_BANKS)
                    if (lane_q == C_LANE_W'(LANES - 1)) begin
                        lane_d = '0;
                        if (bank_q == C_BANK_W'(NUM_BANKS - 1)) begin
                            bank_d = '0;
                            word_d = word_q + ADDR_W'(1);
                        end else begin
                            bank_d = bank_q + C_BANK_W'(1);
                        end
                    end else begin
                        lane_d = lane_q + C_LANE_W'(1);
                    end
                    if (w_elem_next == len_q) begin
                        state_d      = S_DONE;
                        frame_done_d = 1'b1;
                        mem_sel_d    = ~mem_sel_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            bank_q       <= '0;
            word_q       <= '0;
            elem_q       <= '0;
            len_q        <= '0;
            we_q         <= '0;
            mask_q       <= '1;
            waddr_q      <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            mem_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            bank_q       <= bank_d;
            word_q       <= word_d;
            elem_q       <= elem_d;
            len_q        <= len_d;
            we_q         <= we_d;
            mask_q       <= mask_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            mem_sel_q    <= mem_sel_d;
        end
    end

    assign sram_write_enable = we_q;
    assign sram_bytemask     = mask_q;
    assign sram_waddr        = waddr_q;
    assign sram_wdata        = wdata_q;
    assign busy              = busy_q;
    assign frame_done        = frame_done_q;
    assign mem_sel           = mem_sel_q;

endmodule

`default_nettype wire

// File: doc/sram_bank_writer.md
Name: sram_bank_writer

Overview:
- Parametrised write sequencer for one banked activation SRAM group, generalising the fixed 9-bank and 5-bank write ports of the accelerator top.
- Accepts a stream of DATA_W-bit results from a layer engine and scatters each result to one bank, one word and one byte lane.
- Drives a one-hot per-bank write enable plus shared bytemask, waddr and wdata.
- Supports a programmable base address and frame length, and toggles a ping-pong mem_sel at the end of every frame.

Parameters:
- NUM_BANKS, 9, number of SRAM banks in the group (2..16)
- LANES, 4, byte lanes per SRAM word; must be a power of 2
- DATA_W, 8, width of one result and of wdata
- ADDR_W, 10, SRAM word address width
- LEN_W, 14, width of the frame-length field

Ports:
- clk  in  1  clock
- srstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE
- base_addr  in  ADDR_W  first word address of the frame; sampled on an accepted start
- frame_len  in  LEN_W  number of results in the frame; sampled on an accepted start
- in_valid  in  1  result valid
- in_data  in  DATA_W  result byte
- in_ready  out  1  block accepts a result this cycle
- sram_write_enable  out  NUM_BANKS  one-hot write enable; bit b = bank b; active-high
- sram_bytemask  out  LANES  active-low lane mask; 0 = lane written
- sram_waddr  out  ADDR_W  word address
- sram_wdata  out  DATA_W  byte to write
- busy  out  1  high from an accepted start until frame_done
- frame_done  out  1  one-cycle pulse at frame end
- mem_sel  out  1  ping-pong buffer select

Behaviour:
- Reset values (asynchronous, on srstn=0):
  - state=IDLE; all counters 0.
  - sram_write_enable=0, sram_bytemask all 1s, sram_waddr=0, sram_wdata=0.
  - in_ready=0, busy=0, frame_done=0, mem_sel=0.
- State machine IDLE, RUN, DONE:
  - IDLE: start=1 latches base_addr and frame_len and clears the lane, bank, word and element counters. If frame_len≠0, go to RUN; if frame_len=0, go to DONE.
  - RUN: in_ready=1 combinationally. A transfer is in_valid & in_ready. After the transfer that brings the element count to frame_len, go to DONE.
  - DONE: lasts one cycle. frame_done=1 and mem_sel toggles on entry. Then return to IDLE.
  - in_valid is ignored in IDLE and DONE. A start pulse outside IDLE is ignored.
- Address mapping: element k goes to
  - lane = k mod LANES
  - bank = (k / LANES) mod NUM_BANKS
  - word = base_addr + k / (LANES*NUM_BANKS), modulo 2^ADDR_W (wraps silently)
- The mapping is implemented with incrementing counters, not dividers:
  - lane increments every transfer.
  - On lane wrap, bank increments.
  - On bank wrap, word increments.
- Write port is registered, latency 1: a transfer in cycle t produces, in cycle t+1:
  - write_enable with bit bank set
  - bytemask with bit lane cleared and all others set
  - waddr = word
  - wdata = in_data
- In every cycle without a transfer: write_enable=0 and bytemask all 1s; waddr and wdata hold their last value.
- The write for the last element is on the port in the same cycle that frame_done=1.
- busy=1 in RUN and DONE, 0 in IDLE.
- Back-to-back frames: start is accepted in the IDLE cycle after DONE, so the minimum gap between frames is 1 cycle.
- Reset mid-frame: everything returns to reset values immediately, including mem_sel=0, and no further writes are issued.

Test Plan:
- Reset mid-RUN after 5 elements -> write_enable=0 and in_ready=0 immediately. A following start with frame_len=2 writes bank 0 at base_addr and mem_sel restarts from 0.
- start, base_addr=0x010, frame_len=72, in_valid held 1 with data=k -> 72 writes, one per cycle from cycle 2.
  - Element 0: bank0, mask 1110, addr 0x010.
  - Element 3: bank0, mask 0111.
  - Element 4: bank1, mask 1110.
  - Element 36: bank0, addr 0x011.
  - Element 71: bank8, mask 0111, addr 0x011; frame_done coincides with this write; mem_sel goes 0→1.
- Random in_valid gaps (about 50% duty) in a 72-element frame -> identical address, bank and mask sequence; write_enable=0 in every gap cycle.
- base_addr=0x3FF, frame_len=40 -> element 36 writes addr 0x000 (wrap).
- frame_len=0 -> no writes, frame_done 1 cycle after start, mem_sel toggles.
- start pulsed during RUN with different base_addr -> ignored, and the frame completes with the original mapping.
- Two frames back-to-back -> mem_sel 0→1→0.
